// File: rtl/uart_rx_fc_if.sv
// Byte stream carried out of the UART receiver.
// Handshake: a byte transfers on any clk edge where tvalid and tready are both 1;
// tdata is stable while tvalid is 1, and tvalid never waits on tready.
interface uart_rx_fc_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with receive FIFO, AXI-Stream output and RTS flow control.
// Bytes cross to the consumer through a first-word-fall-through circular buffer.
module uart_rx_fc #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic                          rtsn,
  uart_rx_fc_if.master                  m_axis,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          rxd_meta_q, rxd_s_q;
  state_t        state_q;
  logic [15:0]   timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q, overrun_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          rtsn_q;

  logic tick_done, pop, push_ok, push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign tick_done = (timer_q == 16'd0);
  assign pop       = (count_q != '0) && m_axis.tready;
  assign push_ok   = (count_q < CW'(FIFO_DEPTH)) || pop;
  assign push      = (state_q == S_STOP) && tick_done && rxd_s_q && push_ok;

  // Timer counts down to zero; each sample point reloads it for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            state_q <= S_START;
            timer_q <= HALF_LOAD;
          end
        end
        S_START: begin
          if (tick_done) begin
            if (rxd_s_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              timer_q   <= BIT_LOAD;
              bit_idx_q <= 3'd0;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_DATA: begin
          if (tick_done) begin
            shift_q[bit_idx_q] <= rxd_s_q;
            timer_q            <= BIT_LOAD;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_STOP: begin
          if (tick_done) begin
            if (!rxd_s_q) begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end else begin
              overrun_q <= !push_ok;
              state_q   <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_BREAK: begin
          if (rxd_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Next head: a byte pushed into an empty (or draining-to-empty) FIFO bypasses mem.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    tdata_d  = tdata_q;
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) tdata_d = shift_q;
      else                                tdata_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tdata_q  <= 8'h00;
      rtsn_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tdata_q  <= tdata_d;
      rtsn_q   <= (count_d >= CW'(RTS_THRESHOLD));
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = (count_q != '0);
  assign rtsn          = rtsn_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign fifo_count    = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx_fc.sv
// Bench for uart_rx_fc: directed scenarios plus a random phase, all outputs
// compared every cycle against a frame-timing model kept at byte/queue level.
module tb_uart_rx_fc;

  localparam int C  = 16;
  localparam int D  = 4;
  localparam int T  = 3;
  localparam int CW = $clog2(D) + 1;
  localparam int STOP_OFF = C / 2 + 9 * C;

  logic          clk;
  logic          rst;
  logic          rxd;
  logic          rtsn;
  logic          frame_err;
  logic          overrun;
  logic [CW-1:0] fifo_count;
  logic [2:0]    dbg_state;

  uart_rx_fc_if ax();

  uart_rx_fc #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .RTS_THRESHOLD(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rtsn       (rtsn),
    .m_axis     (ax.master),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] e_tdata = 8'h00;
  logic       e_rtsn  = 1'b1;
  logic       e_ferr  = 1'b0;
  logic       e_ovr   = 1'b0;
  int         edge_cnt = 0;
  int         m_start  = -1;
  logic       m_brk    = 1'b0;
  logic [7:0] m_byte   = 8'h00;
  logic       s1 = 1'b1, s2 = 1'b1;

  initial begin
    logic rs, do_push, m_pop;
    int off;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        s1 = 1'b1; s2 = 1'b1;
        m_start = -1; m_brk = 1'b0;
        exp_q.delete();
        e_tdata = 8'h00; e_rtsn = 1'b1; e_ferr = 1'b0; e_ovr = 1'b0;
      end else begin
        edge_cnt++;
        rs = s2; s2 = s1; s1 = rxd;
        e_ferr = 1'b0; e_ovr = 1'b0; do_push = 1'b0;
        if (m_brk) begin
          if (rs) m_brk = 1'b0;
        end else if (m_start < 0) begin
          if (!rs) m_start = edge_cnt;
        end else begin
          off = edge_cnt - m_start;
          if (off == C / 2) begin
            if (rs) m_start = -1;
          end else if (off < STOP_OFF) begin
            if ((off - C / 2) % C == 0) m_byte[(off - C / 2) / C - 1] = rs;
          end else begin
            m_start = -1;
            if (rs) do_push = 1'b1;
            else begin e_ferr = 1'b1; m_brk = 1'b1; end
          end
        end
        m_pop = (exp_q.size() != 0) && ax.tready;
        if (m_pop) void'(exp_q.pop_front());
        if (do_push) begin
          if (exp_q.size() < D) exp_q.push_back(m_byte);
          else e_ovr = 1'b1;
        end
        if (exp_q.size() != 0) e_tdata = exp_q[0];
        e_rtsn = (exp_q.size() >= T);
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] got_q[$];
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  string      lit_name[$];
  int         lit_act[$];
  int         lit_exp[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("tvalid",     int'(ax.tvalid),   int'(exp_q.size() != 0));
      chk("tdata",      int'(ax.tdata),    int'(e_tdata));
      chk("fifo_count", int'(fifo_count),  exp_q.size());
      chk("rtsn",       int'(rtsn),        int'(e_rtsn));
      chk("frame_err",  int'(frame_err),   int'(e_ferr));
      chk("overrun",    int'(overrun),     int'(e_ovr));
      if (ax.tvalid && ax.tready) got_q.push_back(ax.tdata);
      if (frame_err) err_cnt++;
      if (overrun)   ovr_cnt++;
      while (lit_name.size() != 0)
        chk(lit_name.pop_front(), lit_act.pop_front(), lit_exp.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic post(input string nm, input int act, input int exp);
    lit_name.push_back(nm);
    lit_act.push_back(act);
    lit_exp.push_back(exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cyc);
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(C);
    end
    rxd = stop_v;
    tick(stop_cyc);
    rxd = 1'b1;
  endtask

  function automatic int got_at(input int i);
    return (i < got_q.size()) ? int'(got_q[i]) : -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int g0, e0, o0, num_good, guard, s_edge;
    logic [7:0] rb;
    logic rnd_run;
    logic [7:0] t2_bytes[5];
    logic [7:0] t5_bytes[5];
    t2_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    t5_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};

    rst = 1'b1; rxd = 1'b1; ax.tready = 1'b0;
    tick(4);
    post("rst_rtsn",   int'(rtsn), 1);
    post("rst_tvalid", int'(ax.tvalid), 0);
    post("rst_tdata",  int'(ax.tdata), 0);
    post("rst_count",  int'(fifo_count), 0);
    rst = 1'b0;
    tick(1);
    post("rel_rtsn", int'(rtsn), 0);

    // 1: single frame, consumer always ready
    ax.tready = 1'b1;
    g0 = got_q.size(); e0 = err_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, C);
    tick(C);
    post("t1_len",  got_q.size() - g0, 1);
    post("t1_byte", got_at(g0), 8'hA5);
    post("t1_err",  err_cnt - e0, 0);
    post("t1_ovr",  ovr_cnt - o0, 0);

    // 2: five back-to-back frames into a stalled consumer
    ax.tready = 1'b0;
    g0 = got_q.size(); o0 = ovr_cnt;
    for (int i = 0; i < 5; i++) send_frame(t2_bytes[i], 1'b1, C);
    tick(4);
    post("t2_count", int'(fifo_count), 4);
    post("t2_rtsn",  int'(rtsn), 1);
    post("t2_ovr",   ovr_cnt - o0, 1);
    post("t2_none",  got_q.size() - g0, 0);
    ax.tready = 1'b1;
    tick(8);
    post("t2_len", got_q.size() - g0, 4);
    for (int i = 0; i < 4; i++) post("t2_order", got_at(g0 + i), int'(t2_bytes[i]));

    // 3: stop bit held low (break), then a good frame
    g0 = got_q.size(); e0 = err_cnt; o0 = ovr_cnt;
    send_frame(8'h3C, 1'b0, 40 * C);
    tick(2 * C);
    post("t3_err",    err_cnt - e0, 1);
    post("t3_nodata", got_q.size() - g0, 0);
    send_frame(8'h7E, 1'b1, C);
    tick(C);
    post("t3_len",  got_q.size() - g0, 1);
    post("t3_byte", got_at(g0), 8'h7E);
    post("t3_ovr",  ovr_cnt - o0, 0);

    // 4: short low glitch on an idle line
    g0 = got_q.size(); e0 = err_cnt; o0 = ovr_cnt;
    rxd = 1'b0; tick(5); rxd = 1'b1;
    tick(3 * C);
    post("t4_none",   got_q.size() - g0, 0);
    post("t4_pulses", (err_cnt - e0) + (ovr_cnt - o0), 0);

    // 5: full FIFO, pop coincides with the stop sample of the next frame
    ax.tready = 1'b0;
    g0 = got_q.size(); o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) send_frame(t5_bytes[i], 1'b1, C);
    tick(2);
    post("t5_full", int'(fifo_count), 4);
    fork
      send_frame(8'h99, 1'b1, C);
      begin
        guard = 0;
        while (m_start < 0 && guard < 100) begin tick(1); guard++; end
        s_edge = m_start + STOP_OFF;
        while (edge_cnt < s_edge - 1 && guard < 400) begin tick(1); guard++; end
        post("t5_sync", int'(edge_cnt == s_edge - 1), 1);
        ax.tready = 1'b1;
        tick(1);
        ax.tready = 1'b0;
        post("t5_count", int'(fifo_count), 4);
      end
    join
    tick(2);
    post("t5_ovr", ovr_cnt - o0, 0);
    ax.tready = 1'b1;
    tick(8);
    post("t5_len", got_q.size() - g0, 5);
    for (int i = 0; i < 5; i++) post("t5_order", got_at(g0 + i), int'(t5_bytes[i]));

    // 6: reset in the middle of a frame, then a clean frame
    rb = 8'h55;
    rxd = 1'b0; tick(C);
    for (int i = 0; i < 4; i++) begin rxd = rb[i]; tick(C); end
    rst = 1'b1; rxd = 1'b1;
    tick(3);
    post("t6_rst_count", int'(fifo_count), 0);
    post("t6_rst_valid", int'(ax.tvalid), 0);
    rst = 1'b0;
    tick(5);
    g0 = got_q.size(); e0 = err_cnt; o0 = ovr_cnt;
    send_frame(8'h66, 1'b1, C);
    tick(C);
    post("t6_len",    got_q.size() - g0, 1);
    post("t6_byte",   got_at(g0), 8'h66);
    post("t6_pulses", (err_cnt - e0) + (ovr_cnt - o0), 0);

    // random phase: random bytes, gaps, glitches, bad stops and consumer stalls
    g0 = got_q.size(); o0 = ovr_cnt; num_good = 0;
    rnd_run = 1'b1;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          if ($urandom_range(0, 5) == 0) begin
            rxd = 1'b0; tick($urandom_range(1, 6)); rxd = 1'b1; tick(C);
          end
          rb = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) begin
            send_frame(rb, 1'b0, C * $urandom_range(1, 3));
            tick(C);
          end else begin
            send_frame(rb, 1'b1, C);
            num_good++;
          end
          tick($urandom_range(0, C));
        end
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          ax.tready = ($urandom_range(0, 2) != 0);
          tick(1);
        end
      end
    join
    ax.tready = 1'b1;
    tick(4 * C);
    post("rnd_accounting", (got_q.size() - g0) + (ovr_cnt - o0), num_good);
    post("rnd_drained", int'(fifo_count), 0);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
